// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the multi-channel PWM block.
// Optional centre-aligned mode is controlled by PWM_CENTER_ALIGN_EN.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_t;

    localparam int DEF_WIDTH    = 12;
    localparam int DEF_CHANNELS = 4;

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: compares the shared counter against this channel's duty and registers the pin.
// Centre-aligned compare exists only when PWM_CENTER_ALIGN_EN is defined.
module pwm_channel_cmp
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] duty,
    input  pwm_mode_t        mode,
    input  logic             enable,
    input  logic             polarity,
    output logic             out
);

    logic active_cmp;

`ifndef PWM_CENTER_ALIGN_EN
    logic unused_mode;
    assign unused_mode = mode;
`endif

    // A zero period parks every channel at its inactive level.
    always_comb begin
        active_cmp = 1'b0;
        if (period != '0) begin
            if (duty >= period) begin
                active_cmp = 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
            end else if (mode == PWM_CENTER) begin
                active_cmp = (count >= period - duty);
`endif
            end else begin
                active_cmp = (count < duty);
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            out <= 1'b0;
        end else begin
            out <= (active_cmp & enable) ^ polarity;
        end
    end

endmodule

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM: shared period counter, double-buffered settings applied at period boundaries.
// Define PWM_CENTER_ALIGN_EN to enable the centre-aligned (up/down) counting mode.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       polarity,
    input  logic                      center,
    input  logic                      load,
    output logic                      load_pending,
    output logic [WIDTH-1:0]          count,
    output logic                      sync,
    output logic [CHANNELS-1:0]       out
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0]          stg_period,   act_period;
    logic [CHANNELS*WIDTH-1:0] stg_duty,     act_duty;
    logic [CHANNELS-1:0]       stg_enable,   act_enable;
    logic [CHANNELS-1:0]       stg_polarity, act_polarity;
    pwm_mode_t                 stg_mode,     act_mode;
    pwm_mode_t                 in_mode;
    logic                      going_down;
    logic                      last_up;
    logic                      boundary;

`ifdef PWM_CENTER_ALIGN_EN
    logic dir_down;
    assign going_down = dir_down;
    assign in_mode    = center ? PWM_CENTER : PWM_EDGE;
`else
    logic unused_center;
    assign unused_center = center;
    assign going_down    = 1'b0;
    assign in_mode       = PWM_EDGE;
`endif

    assign last_up = (count == act_period - ONE);

    always_comb begin
        boundary = 1'b0;
        if (act_period == '0) begin
            boundary = 1'b1;
        end else if (act_mode == PWM_CENTER) begin
            boundary = going_down && (count == '0);
        end else begin
            boundary = last_up;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            count        <= '0;
            sync         <= 1'b0;
            load_pending <= 1'b0;
            stg_period   <= '0;
            stg_duty     <= '0;
            stg_enable   <= '0;
            stg_polarity <= '0;
            stg_mode     <= PWM_EDGE;
            act_period   <= '0;
            act_duty     <= '0;
            act_enable   <= '0;
            act_polarity <= '0;
            act_mode     <= PWM_EDGE;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down     <= 1'b0;
`endif
        end else begin
            // Only the up-count zero marks a period start; the down-count zero ends it.
            sync <= (act_period != '0) && (count == '0) && !going_down;

            if (load) begin
                stg_period   <= period;
                stg_duty     <= duty;
                stg_enable   <= enable;
                stg_polarity <= polarity;
                stg_mode     <= in_mode;
            end

            if (boundary) begin
                count        <= '0;
                load_pending <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
                dir_down     <= 1'b0;
`endif
                // A load landing on the boundary bypasses staging.
                if (load) begin
                    act_period   <= period;
                    act_duty     <= duty;
                    act_enable   <= enable;
                    act_polarity <= polarity;
                    act_mode     <= in_mode;
                end else if (load_pending) begin
                    act_period   <= stg_period;
                    act_duty     <= stg_duty;
                    act_enable   <= stg_enable;
                    act_polarity <= stg_polarity;
                    act_mode     <= stg_mode;
                end
            end else begin
                if (load) begin
                    load_pending <= 1'b1;
                end
`ifdef PWM_CENTER_ALIGN_EN
                if (act_mode == PWM_CENTER) begin
                    if (dir_down) begin
                        count <= count - ONE;
                    end else if (last_up) begin
                        dir_down <= 1'b1;
                    end else begin
                        count <= count + ONE;
                    end
                end else begin
                    count <= count + ONE;
                end
`else
                count <= count + ONE;
`endif
            end
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        pwm_channel_cmp #(
            .WIDTH(WIDTH)
        ) u_cmp (
            .clk_in   (clk_in),
            .reset    (reset),
            .count    (count),
            .period   (act_period),
            .duty     (act_duty[n*WIDTH +: WIDTH]),
            .mode     (act_mode),
            .enable   (act_enable[n]),
            .polarity (act_polarity[n]),
            .out      (out[n])
        );
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench for pwm_multichannel: table of period/duty settings checked per period via a scoreboard,
// plus hand-written boundary, centre-mode (PWM_CENTER_ALIGN_EN) and reset sequences.
module tb_pwm_multichannel;

    localparam int W = 12;
    localparam int C = 4;

    logic           clk_in = 1'b0;
    logic           reset;
    logic [W-1:0]   period;
    logic [C*W-1:0] duty;
    logic [C-1:0]   enable;
    logic [C-1:0]   polarity;
    logic           center;
    logic           load;
    logic           load_pending;
    logic [W-1:0]   count;
    logic           sync;
    logic [C-1:0]   out;

    pwm_multichannel #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .period       (period),
        .duty         (duty),
        .enable       (enable),
        .polarity     (polarity),
        .center       (center),
        .load         (load),
        .load_pending (load_pending),
        .count        (count),
        .sync         (sync),
        .out          (out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int             p;
        logic [C*W-1:0] d;
        logic [C-1:0]   en;
        logic [C-1:0]   pol;
        logic           ctr;
        int             len;
        int             exp_hi[C];
    } vec_t;

    int           checks = 0;
    int           failures = 0;
    vec_t         sb[$];
    vec_t         vecs[7];
    int           hi_cnt[C];
    int           sync_cnt;
    logic [15:0]  pat0;
    logic         pend_seen;
    logic [W-1:0] prev_count;
    logic [W-1:0] first_prev;

    function automatic vec_t mk(input int p, input int d0, input int d1, input int d2, input int d3,
                                input logic [C-1:0] en, input logic [C-1:0] pol, input logic ctr,
                                input int len, input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v.p = p;
        v.d = {W'(d3), W'(d2), W'(d1), W'(d0)};
        v.en = en;
        v.pol = pol;
        v.ctr = ctr;
        v.len = len;
        v.exp_hi[0] = e0;
        v.exp_hi[1] = e1;
        v.exp_hi[2] = e2;
        v.exp_hi[3] = e3;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        prev_count = count;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_load(input vec_t v);
        period   = v.p[W-1:0];
        duty     = v.d;
        enable   = v.en;
        polarity = v.pol;
        center   = v.ctr;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic wait_pending_clear(input string name);
        int n = 0;
        while (load_pending !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        if (load_pending !== 1'b0) chk({name, "_pend_timeout"}, int'(load_pending), 0);
    endtask

    task automatic wait_sync(input string name);
        int n = 0;
        while (sync !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (sync !== 1'b1) chk({name, "_sync_timeout"}, int'(sync), 1);
    endtask

    task automatic measure(input int len);
        first_prev = prev_count;
        for (int n = 0; n < C; n++) hi_cnt[n] = 0;
        sync_cnt  = 0;
        pat0      = '0;
        pend_seen = 1'b0;
        for (int k = 0; k < len; k++) begin
            for (int n = 0; n < C; n++) if (out[n] === 1'b1) hi_cnt[n]++;
            if (sync === 1'b1) sync_cnt++;
            if (k < 16) pat0[k] = out[0];
            if (load_pending !== 1'b0) pend_seen = 1'b1;
            tick();
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        vec_t e;
        do_load(v);
        sb.push_back(v);
        wait_pending_clear(name);
        tick();
        wait_sync(name);
        measure(v.len);
        e = sb.pop_front();
        for (int n = 0; n < C; n++)
            chk($sformatf("%s_hi%0d", name, n), hi_cnt[n], e.exp_hi[n]);
        chk({name, "_sync_cnt"}, sync_cnt, 1);
        chk({name, "_next_sync"}, int'(sync), 1);
        chk({name, "_sync_lag"}, int'(first_prev), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int   bad;
        int   h0;
        int   n;
        vec_t v;

        vecs[0] = mk(10, 0, 3, 10, 15, 4'hF, 4'h0, 1'b0, 10,  0,  3, 10, 10);
        vecs[1] = mk(10, 4, 4, 4, 4,   4'h3, 4'h5, 1'b0, 10,  6,  4, 10,  0);
        vecs[2] = mk(5,  1, 2, 4, 5,   4'hF, 4'h0, 1'b0, 5,   1,  2,  4,  5);
        vecs[3] = mk(1,  0, 1, 2, 0,   4'hF, 4'h0, 1'b0, 1,   0,  1,  1,  0);
        vecs[4] = mk(16, 8, 15, 16, 0, 4'hF, 4'h8, 1'b0, 16,  8, 15, 16, 16);
        vecs[5] = mk(3,  3, 2, 1, 0,   4'hF, 4'hF, 1'b0, 3,   0,  1,  2,  3);
        vecs[6] = mk(10, 3, 3, 3, 3,   4'hF, 4'h0, 1'b0, 10,  3,  3,  3,  3);

        reset = 1'b1;
        period = '0; duty = '0; enable = '0; polarity = '0; center = 1'b0; load = 1'b0;
        prev_count = '0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_sync", int'(sync), 0);
        chk("rst_out", int'(out), 0);
        chk("rst_pend", int'(load_pending), 0);
        #3 reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (count !== '0 || out !== '0 || sync !== 1'b0) bad++;
        end
        chk("idle_before_load", bad, 0);

        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Mid-period reloads of ch0 duty: the running period must keep D=3, the next gets the last one (7).
        h0 = 0;
        for (int k = 0; k < 10; k++) begin
            h0 += int'(out[0]);
            load = 1'b0;
            if (count == 4) begin
                chk("pend_before", int'(load_pending), 0);
                duty[W-1:0] = 12'd5;
                load = 1'b1;
            end
            if (count == 6) begin
                duty[W-1:0] = 12'd7;
                load = 1'b1;
            end
            if (count == 5) chk("pend_rise", int'(load_pending), 1);
            if (count == 9) chk("pend_hold", int'(load_pending), 1);
            if (count == 0) chk("pend_clear", int'(load_pending), 0);
            tick();
        end
        load = 1'b0;
        chk("cur_period_d0", h0, 3);
        chk("upd_sync", int'(sync), 1);
        measure(10);
        chk("next_period_d0", hi_cnt[0], 7);
        chk("next_period_d1", hi_cnt[1], 3);

        // Load on the terminal cycle goes straight to active.
        n = 0;
        while (count != 9 && n < 20) begin
            tick();
            n++;
        end
        chk("bnd_reach", int'(count), 9);
        duty[W-1:0] = 12'd2;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("bnd_pend", int'(load_pending), 0);
        tick();
        chk("bnd_sync", int'(sync), 1);
        measure(10);
        chk("bnd_d0", hi_cnt[0], 2);
        chk("bnd_pend_window", int'(pend_seen), 0);

`ifdef PWM_CENTER_ALIGN_EN
        v = mk(8, 3, 3, 3, 3, 4'hF, 4'h0, 1'b1, 16, 6, 6, 6, 6);
        run_vec("center", v);
        chk("center_pat", int'(pat0), 16'h07E0);
`else
        v = mk(8, 3, 3, 3, 3, 4'hF, 4'h0, 1'b1, 8, 3, 3, 3, 3);
        run_vec("center_ignored", v);
        chk("center_ignored_pat", int'(pat0), 16'h0007);
`endif

        // Asynchronous reset in the middle of a fully-on period.
        v = mk(10, 10, 10, 10, 10, 4'hF, 4'h0, 1'b0, 10, 10, 10, 10, 10);
        run_vec("full", v);
        n = 0;
        while (count != 5 && n < 20) begin
            tick();
            n++;
        end
        chk("pre_reset_count", int'(count), 5);
        chk("pre_reset_out", int'(out), 15);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_out", int'(out), 0);
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_pend", int'(load_pending), 0);
        @(posedge clk_in);
        #3 reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (count !== '0 || out !== '0 || sync !== 1'b0) bad++;
        end
        chk("idle_after_reset", bad, 0);
        v = mk(10, 4, 4, 4, 4, 4'hF, 4'h0, 1'b0, 10, 4, 4, 4, 4);
        do_load(v);
        tick();
        tick();
        chk("restart_count", int'(count), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_multichannel.md
# pwm_multichannel

Multi-channel PWM generator with one shared period counter and per-channel compare outputs. Period, duty, enable and alignment mode are double-buffered and take effect only at a period boundary, so no output ever shows a truncated or doubled pulse. It drives DAC-reference dimming and LED/test-load outputs on the evaluation-board FPGA designs, where one instance replaces several single-channel PWM blocks.

## Interface
- WIDTH, 12: counter, period and duty width in bits.
- CHANNELS, 4: number of PWM outputs.
- clk_in  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- period  in  WIDTH  period value P.
- duty  in  CHANNELS*WIDTH  per-channel duty D; channel n is duty[n*WIDTH +: WIDTH].
- enable  in  CHANNELS  per-channel enable.
- polarity  in  CHANNELS  per-channel output inversion; 1 means active-low.
- center  in  1  alignment mode: 1 is center-aligned, 0 is edge-aligned.
- load  in  1  single-cycle strobe that captures period, duty, enable, polarity and center into staging.
- load_pending  out  1  high while staged values wait for a boundary.
- count  out  WIDTH  current counter value.
- sync  out  1  one-cycle pulse at the start of each period.
- out  out  CHANNELS  PWM outputs.

## Operation
- Registers are held in three sets: staging, active, and counter/direction.
- **Load:**
  - When load is sampled high, staging captures the inputs and load_pending is set.
  - A second load while pending overwrites staging; load_pending stays high.
- **Boundary (terminal) cycle:**
  - Edge mode: count == P-1.
  - Center mode: count == 0 with direction down.
  - Active P == 0: every cycle is a boundary.
- **At a boundary edge:**
  - If load_pending is set, active <= staging and load_pending clears.
  - Counter restarts at 0 with direction up.
  - If load coincides with the boundary cycle, the inputs go straight to active at that edge and load_pending stays 0.
- **Edge mode:**
  - Counter runs 0..P-1, so the period is P cycles.
  - The channel is active while count < D.
  - D = 0 means never active. D >= P means always active.
- **Center mode:**
  - Counter runs up 0..P-1, repeats P-1, then runs down to 0, so the period is 2P cycles.
  - The channel is active while count >= P-D, giving 2D active cycles centred mid-period.
  - D >= P means always active. D = 0 means never active.
- **P == 0 (both modes):**
  - Counter holds at 0.
  - All outputs sit at their inactive level.
  - sync stays low.
- **Output level:** out[n] = (active_cmp & enable_active[n]) ^ polarity_active[n]. A disabled channel drives its inactive level.
- **Reset:**
  - All registers clear: count, sync, out, load_pending and all staging and active values are 0.
  - The block idles (P = 0) until the first load.
  - Reset asserted mid-period aborts immediately, with no boundary handling.

## Timing
- load to staging: 1 cycle.
- load_pending rises the cycle after load, unless the load fell on a boundary.
- New values apply from the first cycle after the boundary edge. Worst-case latency is one full period.
- out and sync are registered from the current count, so they lag count by exactly 1 cycle.
- sync is high for one cycle, aligned with the out values that correspond to count == 0 at period start.
- Center mode: sync marks the first up-count 0, not the down-count 0.
- No combinational path from any input to any output.

## Configuration
- Macro: PWM_CENTER_ALIGN_EN.
- Defined: center-aligned mode is available as described above.
- Undefined:
  - The center input is ignored and the block is edge-aligned only.
  - The direction register and the P-D subtractor are removed.
  - Staged center reads as 0.

## Structure
- Package pwm_pkg holds:
  - enum pwm_mode_t {PWM_EDGE, PWM_CENTER};
  - default WIDTH/CHANNELS localparams.
- Sub-module pwm_channel_cmp, instantiated CHANNELS times:
  - Inputs: count, active P, D, mode, enable, polarity.
  - Computes and registers one output bit.
- Top level holds:
  - the counter and direction;
  - boundary detection;
  - staging/active registers;
  - sync.

## Test plan
All scenarios use WIDTH=12, CHANNELS=4.
- **Edge mode basic:** load P=10, D={0,3,10,15}, all enabled → per-period high cycles {0,3,10,10}; out[1] high for count 0..2; sync every 10 cycles.
- **Boundary-safe update:** mid-period load D[0] from 3 to 7 at count 4 → load_pending high until count 9; the current period keeps 3 high cycles; the next period has 7.
- **Load on boundary:** load asserted in the count==9 cycle → new values apply the next cycle; load_pending never rises.
- **Center mode (macro defined):** P=8, D=3, center=1 → 16-cycle period; out high 6 cycles for count ≥5 across the top (up 5,6,7, down 7,6,5); sync at up-count 0.
- **Polarity and enable:** polarity=4'b0101, enable=4'b0011, D=4, P=10 → ch0 low 4 / high 6; ch1 high 4; ch2 constant 1; ch3 constant 0.
- **Reset mid-period:** assert reset at count 5 → all outputs 0 asynchronously; after release count stays 0 and out stays 0 until a load with P>0.
